// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge
//   Load/store bridge between the core execute stage and a valid/ready data bus.
//   Legal accesses are issued as one bus transaction while the core is stalled.
//   Illegal accesses are flagged and dropped in a single cycle. A wait counter
//   gives up on a slave that never answers.
//
// Ports
//   clk, reset        : clock, synchronous active-low reset
//   req, we, func3    : memory access request, store select, size/extension
//   addr, wdata       : byte address and store data from the core
//   rdata             : registered, aligned and extended load result
//   stall             : hold PC / block regfile write (combinational)
//   misalign          : current request is illegal (combinational)
//   bus_err           : one-cycle timeout pulse, visible in DONE
//   bus_valid/we/addr/wdata/strb : registered bus request
//   bus_ready, bus_rdata         : slave response
module dmem_bus_bridge #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;
    logic        we_q, we_d;
    logic [31:0] baddr_q, baddr_d;
    logic [31:0] bwdata_q, bwdata_d;
    logic [3:0]  strb_q, strb_d;

    logic        illegal;
    logic        req_idle;
    logic [3:0]  strb_new;
    logic [31:0] wdata_new;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;

    always_comb begin
        case (func3)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = addr[0];
            3'b010:  illegal = (addr[1:0] != 2'b00);
            3'b100:  illegal = we;
            3'b101:  illegal = we | addr[0];
            default: illegal = 1'b1;
        endcase
    end

    assign req_idle = (state_q == S_IDLE) && req;
    assign misalign = reset && req_idle && illegal;
    assign stall    = reset && ((state_q == S_BUS) || (req_idle && !illegal));

    // Size is func3[1:0]; the extension bit does not affect strobes or lanes.
    always_comb begin
        case (func3[1:0])
            2'b00: begin
                strb_new  = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                strb_new  = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                strb_new  = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    // Extraction uses the offset latched at issue, not the live address.
    assign lane_b = bus_rdata[{off_q, 3'b000} +: 8];
    assign lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_val = {24'h0, lane_b};
            3'b101:  load_val = {16'h0, lane_h};
            default: load_val = bus_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        off_d    = off_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        valid_d  = valid_q;
        we_d     = we_q;
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        strb_d   = strb_q;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (req) begin
                    if (illegal) begin
                        rdata_d = 32'h0;
                    end else begin
                        f3_d     = func3;
                        off_d    = addr[1:0];
                        we_d     = we;
                        baddr_d  = {addr[31:2], 2'b00};
                        bwdata_d = wdata_new;
                        strb_d   = strb_new;
                        valid_d  = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (bus_ready) begin
                    valid_d = 1'b0;
                    if (!we_q) rdata_d = load_val;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    valid_d = 1'b0;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            baddr_q  <= 32'h0;
            bwdata_q <= 32'h0;
            strb_q   <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            strb_q   <= strb_d;
        end
    end

    assign rdata     = rdata_q;
    assign bus_err   = err_q;
    assign bus_valid = valid_q;
    assign bus_we    = we_q;
    assign bus_addr  = baddr_q;
    assign bus_wdata = bwdata_q;
    assign bus_strb  = strb_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge, built with TIMEOUT=4.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int n_total = 0;
    int n_pass  = 0;

    dmem_bus_bridge #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .func3     (func3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_strb  (bus_strb),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Next cycle: present a request, then let the checks settle.
    task automatic drive(input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = r; we = w; func3 = f; addr = a; wdata = d;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Zero-wait transaction: IDLE (stall) -> BUS (ready) -> DONE.
    // Returns in the DONE cycle with req already dropped.
    task automatic xfer(input string tag, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] word);
        drive(1'b1, w, f, a, d);
        chk({tag, "_idle_stall"}, {31'h0, stall}, 32'h1);
        @(negedge clk);
        bus_ready = 1'b1; bus_rdata = word; req = 1'b0;
        #1;
        chk({tag, "_bus_valid"}, {31'h0, bus_valid}, 32'h1);
        chk({tag, "_bus_stall"}, {31'h0, stall}, 32'h1);
        @(negedge clk);
        bus_ready = 1'b0; bus_rdata = 32'h0;
        #1;
        chk({tag, "_done_stall"}, {31'h0, stall}, 32'h0);
        chk({tag, "_done_valid"}, {31'h0, bus_valid}, 32'h0);
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; func3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;

        // Reset values, including stall/misalign forced low under reset.
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
        next_cycle();
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        chk("rst_valid", {31'h0, bus_valid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_strb", {28'h0, bus_strb}, 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_err", {31'h0, bus_err}, 32'h0);
        @(negedge clk);
        reset = 1'b1; req = 1'b0;

        // LW 0x100
        xfer("lw", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);
        chk("lw_addr", bus_addr, 32'h0000_0100);
        chk("lw_strb", {28'h0, bus_strb}, 32'hF);
        chk("lw_we", {31'h0, bus_we}, 32'h0);

        // Byte/half extraction from word 0x80FF7F01, back-to-back
        xfer("lb", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_7F01);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        xfer("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_7F01);
        chk("lbu_rdata", rdata, 32'h0000_0080);
        xfer("lhu0", 1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h80FF_7F01);
        chk("lhu0_rdata", rdata, 32'h0000_7F01);
        xfer("lh", 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_7F01);
        chk("lh_rdata", rdata, 32'hFFFF_80FF);

        // Stores: rdata untouched
        xfer("sb", 1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678, 32'hAAAA_AAAA);
        chk("sb_strb", {28'h0, bus_strb}, 32'h2);
        chk("sb_wdata", bus_wdata, 32'h7878_7878);
        chk("sb_we", {31'h0, bus_we}, 32'h1);
        chk("sb_addr", bus_addr, 32'h0000_0200);
        chk("sb_rdata_kept", rdata, 32'hFFFF_80FF);
        xfer("sh", 1'b1, 3'b001, 32'h0000_0202, 32'h1234_5678, 32'h0);
        chk("sh_strb", {28'h0, bus_strb}, 32'hC);
        chk("sh_wdata", bus_wdata, 32'h5678_5678);

        // Misaligned SH 0x201
        drive(1'b1, 1'b1, 3'b001, 32'h0000_0201, 32'h1234_5678);
        chk("mis_sh_flag", {31'h0, misalign}, 32'h1);
        chk("mis_sh_stall", {31'h0, stall}, 32'h0);
        // Misaligned LW 0x302 right after
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0302, 32'h0);
        chk("mis_sh_valid", {31'h0, bus_valid}, 32'h0);
        chk("mis_sh_rdata", rdata, 32'h0);
        chk("mis_lw_flag", {31'h0, misalign}, 32'h1);
        chk("mis_lw_stall", {31'h0, stall}, 32'h0);
        // Store with an unsigned func3
        drive(1'b1, 1'b1, 3'b100, 32'h0000_0300, 32'h0);
        chk("mis_lw_valid", {31'h0, bus_valid}, 32'h0);
        chk("mis_sbu_flag", {31'h0, misalign}, 32'h1);
        drive(1'b1, 1'b0, 3'b011, 32'h0000_0300, 32'h0);
        chk("mis_f3_011_flag", {31'h0, misalign}, 32'h1);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("mis_idle_stall", {31'h0, stall}, 32'h0);
        chk("mis_idle_valid", {31'h0, bus_valid}, 32'h0);

        // Refill rdata so the timeout zeroing is visible
        xfer("lw2", 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1357_9BDF);
        chk("lw2_rdata", rdata, 32'h1357_9BDF);

        // Timeout: 4 BUS cycles with no ready, then DONE with bus_err
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
        @(negedge clk); req = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_bus%0d_valid", i), {31'h0, bus_valid}, 32'h1);
            chk($sformatf("to_bus%0d_stall", i), {31'h0, stall}, 32'h1);
            chk($sformatf("to_bus%0d_err", i), {31'h0, bus_err}, 32'h0);
            next_cycle();
        end
        chk("to_done_err", {31'h0, bus_err}, 32'h1);
        chk("to_done_stall", {31'h0, stall}, 32'h0);
        chk("to_done_valid", {31'h0, bus_valid}, 32'h0);
        chk("to_done_rdata", rdata, 32'h0);
        next_cycle();
        chk("to_err_pulse", {31'h0, bus_err}, 32'h0);

        // Ready on the final count wins
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0);
        @(negedge clk); req = 1'b0; #1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1;
        chk("late_bus4_valid", {31'h0, bus_valid}, 32'h1);
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        chk("late_done_err", {31'h0, bus_err}, 32'h0);
        chk("late_done_stall", {31'h0, stall}, 32'h0);
        chk("late_rdata", rdata, 32'hCAFE_F00D);

        // Reset during the second BUS cycle
        drive(1'b1, 1'b1, 3'b010, 32'h0000_0704, 32'h0BAD_CAFE);
        @(negedge clk); req = 1'b0; #1;
        chk("rb_bus1_valid", {31'h0, bus_valid}, 32'h1);
        @(negedge clk); reset = 1'b0; #1;
        chk("rb_stall_forced", {31'h0, stall}, 32'h0);
        @(negedge clk); reset = 1'b1; #1;
        chk("rb_valid", {31'h0, bus_valid}, 32'h0);
        chk("rb_stall", {31'h0, stall}, 32'h0);
        chk("rb_we", {31'h0, bus_we}, 32'h0);
        chk("rb_addr", bus_addr, 32'h0);
        chk("rb_wdata", bus_wdata, 32'h0);
        chk("rb_strb", {28'h0, bus_strb}, 32'h0);
        chk("rb_rdata", rdata, 32'h0);
        chk("rb_err", {31'h0, bus_err}, 32'h0);
        xfer("rb_lw", 1'b0, 3'b010, 32'h0000_0800, 32'h0, 32'h2468_ACE0);
        chk("rb_lw_rdata", rdata, 32'h2468_ACE0);
        chk("rb_lw_addr", bus_addr, 32'h0000_0800);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
